// File: rtl/dac_frame_rx_if.sv
// ---------------------------------------------------------------------------
// dac_frame_rx_if : DAC serial link pins plus the decoded frame outputs.
//   sclk, sync, din : serial link driven by the transmitter (master)
//   cmd, data       : command/data bytes of the last complete frame
//   valid           : one-clk pulse when cmd/data update
//   cmd_err         : one-clk pulse with valid on a command mismatch
//   short_err       : one-clk pulse when a frame is aborted early
//   frame_cnt       : count of good frames, wrapping
// ---------------------------------------------------------------------------
interface dac_frame_rx_if;
  logic        sclk;
  logic        sync;
  logic        din;
  logic [7:0]  cmd;
  logic [7:0]  data;
  logic        valid;
  logic        cmd_err;
  logic        short_err;
  logic [15:0] frame_cnt;

  modport master (
    output sclk, sync, din,
    input  cmd, data, valid, cmd_err, short_err, frame_cnt
  );

  modport slave (
    input  sclk, sync, din,
    output cmd, data, valid, cmd_err, short_err, frame_cnt
  );
endinterface

// File: rtl/dac_frame_rx.sv
// ---------------------------------------------------------------------------
// dac_frame_rx : oversampling receiver for the DAC serial link.
// Deserialises MSB-first frames (command byte + data byte) on the system
// clock, checks the command byte and counts good frames.
//   clk   : system clock, all logic on its rising edge
//   rst_n : asynchronous active-low reset
//   link  : dac_frame_rx_if slave modport (serial pins in, frame results out)
// ---------------------------------------------------------------------------
module dac_frame_rx #(
  parameter int         FRAME_BITS  = 16,
  parameter logic [7:0] CMD_EXPECT  = 8'h53,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  dac_frame_rx_if.slave link
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [SYNC_STAGES-1:0]  sclk_sync_r;
  logic [SYNC_STAGES-1:0]  sync_sync_r;
  logic [SYNC_STAGES-1:0]  din_sync_r;
  logic                    sclk_prev_r;
  logic                    sclk_s;
  logic                    sync_s;
  logic                    din_s;
  logic                    sclk_fall_s;
  logic [FRAME_BITS-1:0]   sr_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic                    shift_en_s;
  logic                    load_s;
  logic                    abort_s;
  logic                    clr_cnt_s;
  logic [7:0]              cmd_r;
  logic [7:0]              data_r;
  logic                    valid_r;
  logic                    cmd_err_r;
  logic                    short_err_r;
  logic [15:0]             frame_cnt_r;
  logic [7:0]              rx_cmd_s;
  logic [7:0]              rx_data_s;

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign sync_s      = sync_sync_r[SYNC_STAGES-1];
  assign din_s       = din_sync_r[SYNC_STAGES-1];
  // Falling sclk is mid-bit because the transmitter launches on the rise.
  assign sclk_fall_s = sclk_prev_r & ~sclk_s;
  assign rx_cmd_s    = sr_r[FRAME_BITS-1 -: 8];
  assign rx_data_s   = sr_r[7:0];

  // Synchronisers for the asynchronous link pins plus the sclk history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      sync_sync_r <= '0;
      din_sync_r  <= '0;
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], link.sclk};
      sync_sync_r <= {sync_sync_r[SYNC_STAGES-2:0], link.sync};
      din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], link.din};
      sclk_prev_r <= sclk_s;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Frame FSM next-state logic; a sync rise in SHIFT beats a coincident sclk fall.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sync_s) next_state_s = ARMED;
        else        next_state_s = IDLE;
      end
      ARMED: begin
        if (sync_s) next_state_s = ARMED;
        else        next_state_s = SHIFT;
      end
      SHIFT: begin
        if (sync_s)                                  next_state_s = ARMED;
        else if (sclk_fall_s && bit_cnt_r == LAST_BIT) next_state_s = DONE;
        else                                         next_state_s = SHIFT;
      end
      DONE: begin
        next_state_s = WAIT;
      end
      WAIT: begin
        if (sync_s) next_state_s = ARMED;
        else        next_state_s = WAIT;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Frame FSM control outputs for the datapath.
  always_comb begin
    shift_en_s = 1'b0;
    load_s     = 1'b0;
    abort_s    = 1'b0;
    clr_cnt_s  = 1'b0;
    case (state_r)
      ARMED: begin
        clr_cnt_s = 1'b1;
      end
      SHIFT: begin
        if (sync_s) begin
          abort_s = 1'b1;
        end else begin
          shift_en_s = sclk_fall_s;
        end
      end
      DONE: begin
        load_s = 1'b1;
      end
      default: begin
        shift_en_s = 1'b0;
      end
    endcase
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r      <= '0;
      bit_cnt_r <= '0;
    end else if (clr_cnt_s) begin
      bit_cnt_r <= '0;
    end else if (shift_en_s) begin
      sr_r      <= {sr_r[FRAME_BITS-2:0], din_s};
      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
    end
  end

  // Registered frame results and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r       <= 8'h00;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      cmd_err_r   <= 1'b0;
      short_err_r <= 1'b0;
      frame_cnt_r <= 16'h0000;
    end else begin
      valid_r     <= load_s;
      cmd_err_r   <= load_s && (rx_cmd_s != CMD_EXPECT);
      short_err_r <= abort_s;
      if (load_s) begin
        cmd_r  <= rx_cmd_s;
        data_r <= rx_data_s;
        if (rx_cmd_s == CMD_EXPECT) begin
          frame_cnt_r <= frame_cnt_r + 16'd1;
        end
      end
    end
  end

  assign link.cmd       = cmd_r;
  assign link.data      = data_r;
  assign link.valid     = valid_r;
  assign link.cmd_err   = cmd_err_r;
  assign link.short_err = short_err_r;
  assign link.frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_dac_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_dac_frame_rx : scoreboard bench for dac_frame_rx. Stimulus pushes the
// expected frame result; a monitor pops and compares on every valid pulse.
// ---------------------------------------------------------------------------
module tb_dac_frame_rx;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  data;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  dac_frame_rx_if link ();

  exp_t        q[$];
  int          n_checks;
  int          n_fail;
  int          short_seen;
  int          exp_short;
  logic [15:0] exp_cnt;

  dac_frame_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Expected result of a frame that completes its 16 bits.
  task automatic expect_frame(input logic [15:0] word);
    exp_t e;
    e.cmd  = word[15:8];
    e.data = word[7:0];
    e.err  = (word[15:8] != 8'h53);
    if (!e.err) exp_cnt = exp_cnt + 16'd1;
    e.cnt  = exp_cnt;
    q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_pulse();
    link.sync = 1'b1;
    wait_clk(8);
    link.sync = 1'b0;
    wait_clk(4);
  endtask

  // sclk = clk/8; din launched on the rise, bits beyond 16 are ones.
  task automatic shift_bits(input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      link.din  = (i < 16) ? word[15-i] : 1'b1;
      link.sclk = 1'b1;
      wait_clk(4);
      link.sclk = 1'b0;
      wait_clk(4);
    end
  endtask

  task automatic send_frame(input logic [15:0] word);
    expect_frame(word);
    sync_pulse();
    shift_bits(word, 16);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd"},       {24'd0, link.cmd},        32'd0);
    check({tag, "_data"},      {24'd0, link.data},       32'd0);
    check({tag, "_valid"},     {31'd0, link.valid},      32'd0);
    check({tag, "_cmd_err"},   {31'd0, link.cmd_err},    32'd0);
    check({tag, "_short_err"}, {31'd0, link.short_err},  32'd0);
    check({tag, "_frame_cnt"}, {16'd0, link.frame_cnt},  32'd0);
  endtask

  // Monitor: compare every valid pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (link.short_err) short_seen++;
      if (link.valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL valid_expected: actual valid with empty scoreboard, required no valid");
        end else begin
          exp_t e;
          e = q.pop_front();
          check("mon_cmd",       {24'd0, link.cmd},       {24'd0, e.cmd});
          check("mon_data",      {24'd0, link.data},      {24'd0, e.data});
          check("mon_cmd_err",   {31'd0, link.cmd_err},   {31'd0, e.err});
          check("mon_frame_cnt", {16'd0, link.frame_cnt}, {16'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    short_seen = 0;
    exp_short  = 0;
    exp_cnt    = 16'd0;
    rst_n      = 1'b0;
    link.sclk  = 1'b0;
    link.sync  = 1'b0;
    link.din   = 1'b0;
    wait_clk(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clk(4);

    // Nominal frame.
    send_frame(16'h53A5);
    wait_clk(10);
    check("nominal_cnt", {16'd0, link.frame_cnt}, 32'd1);

    // Back-to-back frames with a one-sclk sync gap.
    for (int i = 0; i < 256; i++) begin
      send_frame({8'h53, 8'(i)});
    end
    wait_clk(10);
    check("b2b_cnt", {16'd0, link.frame_cnt}, 32'd257);
    check("b2b_short", short_seen, 0);

    // Bad command: outputs update, count holds.
    send_frame(16'h1234);
    wait_clk(10);
    check("bad_cnt", {16'd0, link.frame_cnt}, 32'd257);

    // Short frame aborted after 9 bits by the next sync.
    sync_pulse();
    shift_bits(16'h5388, 9);
    exp_short = exp_short + 1;
    sync_pulse();
    check("short_pulse", short_seen, exp_short);
    check("short_hold_cmd",  {24'd0, link.cmd},  32'h12);
    check("short_hold_data", {24'd0, link.data}, 32'h34);
    expect_frame(16'h5307);
    shift_bits(16'h5307, 16);
    wait_clk(10);
    check("after_short_data", {24'd0, link.data}, 32'h07);

    // Overrun: 20 falls, only the first 16 bits count.
    expect_frame(16'h53C3);
    sync_pulse();
    shift_bits(16'h53C3, 20);
    wait_clk(10);
    check("overrun_data", {24'd0, link.data}, 32'hC3);

    // Reset mid-frame.
    sync_pulse();
    shift_bits(16'h53AA, 8);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    wait_clk(3);
    rst_n   = 1'b1;
    exp_cnt = 16'd0;
    wait_clk(4);
    send_frame(16'h53FF);
    wait_clk(10);
    check("post_reset_data", {24'd0, link.data}, 32'hFF);
    check("post_reset_cnt",  {16'd0, link.frame_cnt}, 32'd1);

    // Frame counter wrap from 16'hFFFF.
    force dut.frame_cnt_r = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_cnt_r;
    wait_clk(2);
    check("wrap_preset", {16'd0, link.frame_cnt}, 32'hFFFF);
    exp_cnt = 16'hFFFF;
    send_frame(16'h53FF);
    wait_clk(10);
    check("wrap_cnt", {16'd0, link.frame_cnt}, 32'd0);

    // Drain and final accounting.
    for (int i = 0; i < 100 && q.size() != 0; i++) wait_clk(1);
    check("scoreboard_empty", q.size(), 0);
    check("short_total", short_seen, exp_short);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
